base_proc: RTL and testbench

Multi-cycle 16-bit processor core with eight general-purpose registers. It is the device under test that the testbench instruction driver talks to. It accepts one instruction per `run` request on `din`, executes it (mv, mvi, add, sub, mvo), pulses `done` for one cycle on completion, and drives `dout` on mvo. It sits between the bench driver and any future memory/bus wrapper.

---
 rtl/base_proc.sv | 163 ++++++++++++++++
 tb/tb_base_proc.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_proc.sv
// Multi-cycle 16-bit processor core with eight general-purpose registers.
// Executes one instruction (mv, mvi, add, sub, mvo) per run request and pulses done on completion.
module base_proc (
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] din,
    output logic        done,
    output logic [15:0] dout
);

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MVO = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [8:0]  ir;
    logic [15:0] g;
    logic [15:0] rf [8];

    logic [2:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] rx_val;
    logic [15:0] ry_val;

    logic        ir_load;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic        g_we;
    logic [15:0] g_next;
    logic        dout_we;
    logic        done_next;

    // Modulo-2^16 arithmetic; carries are deliberately discarded.
    function automatic logic [15:0] alu_add(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    function automatic logic [15:0] alu_sub(input logic [15:0] a, input logic [15:0] b);
        return a - b;
    endfunction

    assign op     = ir[8:6];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];
    assign rx_val = rf[rx];
    assign ry_val = rf[ry];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        rf_we      = 1'b0;
        rf_wdata   = 16'h0000;
        g_we       = 1'b0;
        g_next     = 16'h0000;
        dout_we    = 1'b0;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (run) begin
                    ir_load    = 1'b1;
                    state_next = EXEC;
                end
            end

            EXEC: begin
                state_next = IDLE;
                done_next  = 1'b1;
                case (op)
                    OP_MV: begin
                        rf_we    = 1'b1;
                        rf_wdata = ry_val;
                    end
                    OP_MVI: begin
                        // Immediate word is whatever sits on din at this edge.
                        rf_we    = 1'b1;
                        rf_wdata = din;
                    end
                    OP_ADD: begin
                        g_we       = 1'b1;
                        g_next     = alu_add(rx_val, ry_val);
                        done_next  = 1'b0;
                        state_next = WB;
                    end
                    OP_SUB: begin
                        g_we       = 1'b1;
                        g_next     = alu_sub(rx_val, ry_val);
                        done_next  = 1'b0;
                        state_next = WB;
                    end
                    OP_MVO: begin
                        dout_we = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            WB: begin
                rf_we      = 1'b1;
                rf_wdata   = g;
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ir   <= 9'h000;
            g    <= 16'h0000;
            dout <= 16'h0000;
            done <= 1'b0;
        end else begin
            done <= done_next;
            if (ir_load) begin
                ir <= din[8:0];
            end
            if (g_we) begin
                g <= g_next;
            end
            if (dout_we) begin
                dout <= rx_val;
            end
        end
    end

    // Register file: single write port, always targeting rx of the current instruction.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= 16'h0000;
            end
        end else if (rf_we) begin
            rf[rx] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_base_proc.sv
// Directed self-checking bench for base_proc: one task per scenario, expected values hand-computed.
module tb_base_proc;

    logic        clock;
    logic        resetn;
    logic        run;
    logic [15:0] din;
    logic        done;
    logic [15:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    base_proc dut (
        .clock (clock),
        .resetn(resetn),
        .run   (run),
        .din   (din),
        .done  (done),
        .dout  (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [2:0] MV  = 3'b000;
    localparam logic [2:0] MVI = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;
    localparam logic [2:0] MVO = 3'b100;
    localparam logic [2:0] NOP = 3'b111;

    // Drives one instruction with a single-cycle run pulse. lat = edges from capture to done
    // (-1 if done never arrives); done_after = done one edge after the pulse.
    task automatic issue(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input logic [15:0] imm, output int lat, output logic done_after);
        bit seen;
        @(negedge clock);
        din = {7'b1010101, op, rx, ry};
        run = 1'b1;
        @(posedge clock);
        #1;
        run  = 1'b0;
        din  = imm;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (done) seen = 1;
        end
        if (!seen) lat = -1;
        @(posedge clock);
        #1;
        done_after = done;
    endtask

    task automatic read_reg(input logic [2:0] rx, output logic [15:0] val);
        int   lat;
        logic da;
        issue(MVO, rx, 3'd0, 16'h0000, lat, da);
        val = dout;
    endtask

    task automatic write_reg(input logic [2:0] rx, input logic [15:0] val);
        int   lat;
        logic da;
        issue(MVI, rx, 3'd0, val, lat, da);
    endtask

    task automatic test_reset();
        int          lat;
        logic        da;
        logic [15:0] v;
        resetn = 1'b0;
        run    = 1'b0;
        din    = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", dout); end
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL idle_no_run_done: got %b expected 0", done); end
        issue(MVO, 3'd0, 3'd0, 16'h0000, lat, da);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL mvo_r0_latency: got %0d expected 1", lat); end
        n_checks++;
        if (da !== 1'b0) begin n_fail++; $display("FAIL mvo_r0_done_width: got %b expected 0", da); end
        n_checks++;
        if (dout !== 16'h0000) begin n_fail++; $display("FAIL mvo_r0_dout: got %h expected 0000", dout); end
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), v);
            n_checks++;
            if (v !== 16'h0000) begin n_fail++; $display("FAIL init_r%0d: got %h expected 0000", r, v); end
        end
    endtask

    task automatic test_mvi();
        int          lat;
        logic        da;
        logic [15:0] v;
        issue(MVI, 3'd3, 3'd0, 16'h1234, lat, da);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL mvi_latency: got %0d expected 1", lat); end
        n_checks++;
        if (da !== 1'b0) begin n_fail++; $display("FAIL mvi_done_width: got %b expected 0", da); end
        read_reg(3'd3, v);
        n_checks++;
        if (v !== 16'h1234) begin n_fail++; $display("FAIL mvi_r3: got %h expected 1234", v); end
        for (int r = 0; r < 8; r++) write_reg(3'(r), 16'(r));
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), v);
            n_checks++;
            if (v !== 16'(r)) begin n_fail++; $display("FAIL mvi_r%0d: got %h expected %h", r, v, 16'(r)); end
        end
    endtask

    task automatic test_add();
        int          lat;
        logic        da;
        logic [15:0] v;
        write_reg(3'd1, 16'hFFFF);
        write_reg(3'd2, 16'h0002);
        issue(ADD, 3'd1, 3'd2, 16'h0000, lat, da);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
        n_checks++;
        if (da !== 1'b0) begin n_fail++; $display("FAIL add_done_width: got %b expected 0", da); end
        read_reg(3'd1, v);
        n_checks++;
        if (v !== 16'h0001) begin n_fail++; $display("FAIL add_wrap: got %h expected 0001", v); end
        read_reg(3'd2, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL add_ry_kept: got %h expected 0002", v); end
    endtask

    task automatic test_sub();
        int          lat;
        logic        da;
        logic [15:0] v;
        write_reg(3'd4, 16'h0005);
        write_reg(3'd5, 16'h0007);
        issue(SUB, 3'd4, 3'd5, 16'h0000, lat, da);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL sub_latency: got %0d expected 2", lat); end
        read_reg(3'd4, v);
        n_checks++;
        if (v !== 16'hFFFE) begin n_fail++; $display("FAIL sub_wrap: got %h expected fffe", v); end
        issue(SUB, 3'd4, 3'd4, 16'h0000, lat, da);
        read_reg(3'd4, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL sub_self: got %h expected 0000", v); end
        issue(ADD, 3'd5, 3'd5, 16'h0000, lat, da);
        read_reg(3'd5, v);
        n_checks++;
        if (v !== 16'h000E) begin n_fail++; $display("FAIL add_self: got %h expected 000e", v); end
    endtask

    task automatic test_mv_nop();
        int          lat;
        logic        da;
        logic [15:0] v;
        write_reg(3'd6, 16'hBEEF);
        write_reg(3'd1, 16'h1111);
        issue(MV, 3'd1, 3'd6, 16'h0000, lat, da);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL mv_latency: got %0d expected 1", lat); end
        read_reg(3'd1, v);
        n_checks++;
        if (v !== 16'hBEEF) begin n_fail++; $display("FAIL mv_r1: got %h expected beef", v); end
        issue(MV, 3'd6, 3'd6, 16'h0000, lat, da);
        read_reg(3'd6, v);
        n_checks++;
        if (v !== 16'hBEEF) begin n_fail++; $display("FAIL mv_self: got %h expected beef", v); end
        issue(NOP, 3'd1, 3'd2, 16'h5A5A, lat, da);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL nop_latency: got %0d expected 1", lat); end
        n_checks++;
        if (da !== 1'b0) begin n_fail++; $display("FAIL nop_done_width: got %b expected 0", da); end
        n_checks++;
        if (dout !== 16'hBEEF) begin n_fail++; $display("FAIL nop_dout_hold: got %h expected beef", dout); end
        read_reg(3'd1, v);
        n_checks++;
        if (v !== 16'hBEEF) begin n_fail++; $display("FAIL nop_r1_kept: got %h expected beef", v); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        write_reg(3'd7, 16'h0010);
        @(negedge clock);
        din = {7'b0, ADD, 3'd7, 3'd7};
        run = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        n_checks++;
        if (dout !== 16'h0000) begin n_fail++; $display("FAIL midreset_dout: got %h expected 0000", dout); end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done_held: got %b expected 0", done); end
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL postreset_done: got %b expected 0", done); end
        read_reg(3'd7, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL midreset_r7: got %h expected 0000", v); end
    endtask

    task automatic test_back_to_back();
        write_reg(3'd2, 16'hAAAA);
        write_reg(3'd3, 16'h5555);
        @(negedge clock);
        din = {7'b0, MVO, 3'd2, 3'd0};
        run = 1'b1;
        @(posedge clock);
        #1;
        din = {7'b0, MVO, 3'd3, 3'd0};
        @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b expected 1", done); end
        n_checks++;
        if (dout !== 16'hAAAA) begin n_fail++; $display("FAIL b2b_dout1: got %h expected aaaa", dout); end
        @(posedge clock);
        #1;
        run = 1'b0;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b expected 0", done); end
        @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b expected 1", done); end
        n_checks++;
        if (dout !== 16'h5555) begin n_fail++; $display("FAIL b2b_dout2: got %h expected 5555", dout); end
        @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end: got %b expected 0", done); end
        n_checks++;
        if (dout !== 16'h5555) begin n_fail++; $display("FAIL b2b_dout_hold: got %h expected 5555", dout); end
    endtask

    initial begin
        resetn = 1'b0;
        run    = 1'b0;
        din    = 16'h0000;
        test_reset();
        test_mvi();
        test_add();
        test_sub();
        test_mv_nop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
